// File: rtl/pix_reader.sv
// Frame reader: streams an IMG_W x IMG_H raster from a fixed-latency memory into
// a valid/ready pixel stream through a 4-entry FIFO guarded by read credits.
module pix_reader #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic [8:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);
    localparam logic [8:0] X_MAX = 9'(IMG_W - 1);
    localparam logic [8:0] Y_MAX = 9'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [8:0]        rd_x;
    logic [8:0]        rd_y;
    logic [ADDR_W-1:0] rd_addr;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_l;
    logic [8:0]        tag_x [RD_LAT];
    logic [8:0]        tag_y [RD_LAT];
    logic [2:0]        in_flight;

    logic [DATA_W-1:0] f_data [4];
    logic [8:0]        f_x [4];
    logic [8:0]        f_y [4];
    logic [3:0]        f_last;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;

    logic       push;
    logic       pop;
    logic       issue;
    logic       rd_last;
    logic [3:0] pending;

    always_comb begin
        rd_last   = (rd_x == X_MAX) && (rd_y == Y_MAX);
        push      = tag_v[RD_LAT-1];
        pix_valid = !rst && (count != 3'd0);
        pop       = pix_valid && pix_ready;
        pending   = 4'(count) + 4'(in_flight);
        // The slot freed by this cycle's pop is credited now, so RD_LAT=3 still streams 1 pixel/cycle.
        issue     = !rst && (state == RUN) && (pending < 4'd4 + 4'(pop));
        mem_rd_en = issue;
        mem_addr  = rst ? '0 : rd_addr;
        busy      = !rst && ((state == RUN) || (state == DRAIN));
        done      = !rst && (state == DONE);
        pix_data  = pix_valid ? f_data[rd_ptr] : '0;
        pix_x     = pix_valid ? f_x[rd_ptr] : '0;
        pix_y     = pix_valid ? f_y[rd_ptr] : '0;
        pix_last  = pix_valid && f_last[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_addr   <= '0;
            tag_v     <= '0;
            in_flight <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    rd_x    <= '0;
                    rd_y    <= '0;
                    rd_addr <= '0;
                end
                RUN:     if (issue && rd_last) state <= DRAIN;
                DRAIN:   if (pop && pix_last) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                if (rd_x == X_MAX) begin
                    rd_x <= '0;
                    rd_y <= rd_y + 9'd1;
                end else begin
                    rd_x <= rd_x + 9'd1;
                end
            end

            tag_v[0] <= issue;
            tag_l[0] <= rd_last;
            tag_x[0] <= rd_x;
            tag_y[0] <= rd_y;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
                tag_x[i] <= tag_x[i-1];
                tag_y[i] <= tag_y[i-1];
            end
            in_flight <= in_flight + 3'(issue) - 3'(push);

            if (push) begin
                f_data[wr_ptr] <= mem_rd_data;
                f_x[wr_ptr]    <= tag_x[RD_LAT-1];
                f_y[wr_ptr]    <= tag_y[RD_LAT-1];
                f_last[wr_ptr] <= tag_l[RD_LAT-1];
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
    end
endmodule
